systolic_result_serializer: RTL and testbench

//  Parametrised successor to the fixed 512->64 output path of the systolic array. Queues full result

---
 rtl/systolic_result_serializer.sv | 170 +++++++++++++++++
 tb/tb_systolic_result_serializer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_result_serializer.sv
// systolic_result_serializer
// Queues IN_W-bit result words from the systolic array in a DEPTH-entry FIFO and
// streams each word as IN_W/OUT_W beats over a ready/valid interface, with beat
// index, last-beat flag and a one-cycle frame_done pulse per word.
// Build option: define SER_MSB_FIRST_EN to emit the most significant beat first;
// by default beat 0 is the least significant OUT_W bits of the word.
module systolic_result_serializer #(
    parameter int IN_W  = 512,
    parameter int OUT_W = 64,
    parameter int DEPTH = 2,
    localparam int BEATS  = IN_W / OUT_W,
    localparam int BEAT_W = $clog2(BEATS),
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output logic [BEAT_W-1:0] out_beat,
    output logic              frame_done,
    output logic [CNT_W-1:0]  fifo_count
);

    typedef enum logic {
        IDLE = 1'b0,   // shifter empty
        SEND = 1'b1    // shifter holds a word being streamed
    } state_t;

    state_t             state_q, state_d;
    logic [IN_W-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IN_W-1:0]    shift_q, shift_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               frame_done_q, frame_done_d;

    logic push;
    logic pop;
    logic beat_hs;
    logic last_hs;
    logic fifo_nempty;

    // Pointer advance that wraps modulo DEPTH (also correct for non-power-of-two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Move the next beat into the output window of the shifter; vacated bits fill with zero.
    function automatic logic [IN_W-1:0] shift_next(input logic [IN_W-1:0] s);
`ifdef SER_MSB_FIRST_EN
        return s << OUT_W;
`else
        return s >> OUT_W;
`endif
    endfunction

    // Handshake qualifiers; in_ready uses only the registered count, so a same-cycle pop
    // never lets a word write through a full FIFO.
    always_comb begin
        fifo_nempty = (count_q != '0);
        in_ready    = !reset && (count_q < CNT_W'(DEPTH));
        push        = in_valid && in_ready;
        beat_hs     = (state_q == SEND) && out_ready;
        last_hs     = beat_hs && (beat_q == BEAT_W'(BEATS - 1));
    end

    // Serializer FSM: loads the FIFO head into the shifter and steps through the beats,
    // reloading on the last-beat handshake so consecutive words stream without a bubble.
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        shift_d      = shift_q;
        beat_d       = beat_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_nempty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    beat_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (last_hs) begin
                    frame_done_d = 1'b1;
                    beat_d       = '0;
                    if (fifo_nempty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                    end else begin
                        shift_d = shift_next(shift_q);
                        state_d = IDLE;
                    end
                end else if (beat_hs) begin
                    beat_d  = beat_q + BEAT_W'(1);
                    shift_d = shift_next(shift_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO pointer and occupancy next-state; push and pop together leave the count unchanged.
    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // State, pointers, shifter and beat counter; reset drops all queued and partial data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            shift_q      <= '0;
            beat_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            shift_q      <= shift_d;
            beat_q       <= beat_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Output mapping; the beat window is fixed so data holds while the sink stalls.
    always_comb begin
        out_valid  = (state_q == SEND);
`ifdef SER_MSB_FIRST_EN
        out_data   = shift_q[IN_W-1 -: OUT_W];
`else
        out_data   = shift_q[OUT_W-1:0];
`endif
        out_beat   = beat_q;
        out_last   = (beat_q == BEAT_W'(BEATS - 1));
        frame_done = frame_done_q;
        fifo_count = count_q;
    end

endmodule

// File: tb/tb_systolic_result_serializer.sv
// Scoreboard bench for systolic_result_serializer (IN_W=512, OUT_W=64, DEPTH=2).
// Accepted words are expanded into expected beats by a reference model; a monitor
// pops and compares on every beat handshake. Honours SER_MSB_FIRST_EN.
module tb_systolic_result_serializer;

    localparam int IN_W  = 512;
    localparam int OUT_W = 64;
    localparam int DEPTH = 2;
    localparam int BEATS = IN_W / OUT_W;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [OUT_W-1:0] out_data;
    logic             out_last;
    logic [2:0]       out_beat;
    logic             frame_done;
    logic [1:0]       fifo_count;

    systolic_result_serializer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_beat(out_beat),
        .frame_done(frame_done), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready, 3: pattern 1,0,0
    logic [OUT_W-1:0] exp_data [$];
    int               exp_idx  [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference model: word -> ordered list of beats using plain shifts.
    task automatic model_push(input logic [IN_W-1:0] w);
        for (int k = 0; k < BEATS; k++) begin
`ifdef SER_MSB_FIRST_EN
            exp_data.push_back(OUT_W'(w >> ((BEATS - 1 - k) * OUT_W)));
`else
            exp_data.push_back(OUT_W'(w >> (k * OUT_W)));
`endif
            exp_idx.push_back(k);
        end
    endtask

    function automatic logic [IN_W-1:0] rand_word();
        logic [IN_W-1:0] w;
        for (int i = 0; i < IN_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Offers a word until accepted; returns just after the accepting edge.
    task automatic push_word(input logic [IN_W-1:0] w);
        int  t = 0;
        bit  done = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                model_push(w);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!done) begin
                t++;
                if (t > 300) begin
                    chk("push_timeout", 64'd1, 64'd0);
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
        in_data  = rand_word();
    endtask

    task automatic wait_drain();
        int t = 0;
        while (t < 3000) begin
            @(negedge clk);
            if (exp_data.size() == 0 && !out_valid) break;
            t++;
        end
        chk("drain_left", 64'(exp_data.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // out_ready driver
    initial begin
        int p = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: out_ready = 1'b0;
                default: begin
                    out_ready = (p % 3 == 0);
                    p++;
                end
            endcase
        end
    end

    // Monitor: scoreboard compare on every beat handshake, frame_done and stall stability.
    initial begin
        logic             fd_exp = 1'b0;
        logic             prev_stall = 1'b0;
        logic [OUT_W-1:0] prev_data = '0;
        logic [2:0]       prev_beat = '0;
        logic [OUT_W-1:0] ed;
        int               ei;
        forever begin
            @(negedge clk);
            if (reset) begin
                fd_exp     = 1'b0;
                prev_stall = 1'b0;
            end else begin
                chk("frame_done", 64'(frame_done), 64'(fd_exp));
                fd_exp = 1'b0;
                if (prev_stall) begin
                    chk("stall_data", 64'(out_data), 64'(prev_data));
                    chk("stall_beat", 64'(out_beat), 64'(prev_beat));
                end
                if (out_valid && out_ready) begin
                    if (exp_data.size() == 0) begin
                        chk("unexpected_beat", 64'd1, 64'd0);
                    end else begin
                        ed = exp_data.pop_front();
                        ei = exp_idx.pop_front();
                        chk("beat_data", 64'(out_data), 64'(ed));
                        chk("beat_index", 64'(out_beat), 64'(ei));
                        chk("beat_last", 64'(out_last), 64'(ei == BEATS - 1));
                        fd_exp = (ei == BEATS - 1);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_beat  = out_beat;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IN_W-1:0] w;
        logic [63:0]     first_beat;
        int              fd_pos [$];
        int              first_gap;
        bit              saw_full;
        int              t;

`ifdef SER_MSB_FIRST_EN
        first_beat = 64'd7;
`else
        first_beat = 64'd0;
`endif

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_beat", 64'(out_beat), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_fifo_count", 64'(fifo_count), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // 1. Single word, beat k = k, latency and timing
        rdy_mode = 0;
        for (int k = 0; k < BEATS; k++) w[k*OUT_W +: OUT_W] = OUT_W'(k);
        push_word(w);
        @(negedge clk);
        chk("t1_valid_after_accept", 64'(out_valid), 64'd0);
        chk("t1_count_after_accept", 64'(fifo_count), 64'd1);
        @(negedge clk);
        chk("t1_first_valid", 64'(out_valid), 64'd1);
        chk("t1_first_beat_idx", 64'(out_beat), 64'd0);
        chk("t1_first_beat_data", 64'(out_data), first_beat);
        for (int i = 1; i < BEATS; i++) begin
            @(negedge clk);
            chk("t1_valid_run", 64'(out_valid), 64'd1);
            chk("t1_beat_seq", 64'(out_beat), 64'(i));
        end
        chk("t1_last_on_7", 64'(out_last), 64'd1);
        @(negedge clk);
        chk("t1_frame_done", 64'(frame_done), 64'd1);
        chk("t1_idle_after", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // 2. Three words back-to-back: no bubbles, frame_done every 8 cycles
        fd_pos.delete();
        first_gap = -1;
        saw_full  = 1'b0;
        fork
            begin
                push_word(rand_word());
                push_word(rand_word());
                push_word(rand_word());
            end
            begin
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!out_valid && t < 20);
                for (int i = 0; i < 30; i++) begin
                    if (i > 0) @(negedge clk);
                    if (!out_valid && first_gap < 0) first_gap = i;
                    if (frame_done) fd_pos.push_back(i);
                    if (!in_ready && fifo_count == 2'd2) saw_full = 1'b1;
                end
            end
        join
        chk("t2_contiguous_beats", 64'(first_gap), 64'd24);
        chk("t2_frame_pulses", 64'(fd_pos.size()), 64'd3);
        chk("t2_saw_full", 64'(saw_full), 64'd1);
        if (fd_pos.size() == 3) begin
            chk("t2_fd_first", 64'(fd_pos[0]), 64'd8);
            chk("t2_fd_gap1", 64'(fd_pos[1] - fd_pos[0]), 64'd8);
            chk("t2_fd_gap2", 64'(fd_pos[2] - fd_pos[1]), 64'd8);
        end
        @(posedge clk);
        #1;
        wait_drain();

        // 3. Stalling sink 1,0,0 pattern
        rdy_mode = 3;
        push_word(rand_word());
        wait_drain();

        // 4. Full FIFO with a pending word while the last beat pops
        rdy_mode = 2;
        push_word(rand_word());
        push_word(rand_word());
        push_word(rand_word());
        w = rand_word();
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        chk("t4_full_count", 64'(fifo_count), 64'd2);
        chk("t4_full_in_ready", 64'(in_ready), 64'd0);
        rdy_mode = 0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(out_valid && out_ready && out_last) && t < 50);
        chk("t4_last_found", 64'(t < 50), 64'd1);
        chk("t4_count_at_pop", 64'(fifo_count), 64'd2);
        chk("t4_in_ready_at_pop", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t4_count_after_pop", 64'(fifo_count), 64'd1);
        chk("t4_in_ready_after_pop", 64'(in_ready), 64'd1);
        model_push(w);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4_count_after_push", 64'(fifo_count), 64'd2);
        @(posedge clk);
        #1;
        wait_drain();

        // 5. Reset mid-word with a second word queued
        rdy_mode = 0;
        push_word(rand_word());
        push_word(rand_word());
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(out_valid && out_beat == 3'd3) && t < 30);
        chk("t5_beat3_found", 64'(t < 30), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_data.delete();
        exp_idx.delete();
        @(negedge clk);
        chk("t5_in_ready_in_reset", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_fifo_count", 64'(fifo_count), 64'd0);
        chk("t5_out_beat", 64'(out_beat), 64'd0);
        chk("t5_in_ready", 64'(in_ready), 64'd1);
        repeat (30) @(negedge clk);
        @(posedge clk);
        #1;

        // Randomized traffic with random sink backpressure
        rdy_mode = 1;
        for (int n = 0; n < 25; n++) begin
            push_word(rand_word());
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
